// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: command record, response codes, FSM states.
package i2c_pkg;

  typedef struct packed {
    logic [6:0]  slave_addr;
    logic        rw;
    logic [7:0]  reg_addr;
    logic [2:0]  trans;
    logic [63:0] wdata;
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    NACK    = 2'b01,
    ACC_TO  = 2'b10,
    DONE_TO = 2'b11
  } rsp_err_e;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } seq_state_e;

endpackage

// File: rtl/i2c_cmd_seq_if.sv
// Host command/response channel plus the master start/busy handshake.
interface i2c_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_slave_addr;
  logic        cmd_rw;
  logic [7:0]  cmd_reg_addr;
  logic [2:0]  cmd_trans;
  logic [63:0] cmd_wdata;
  logic        m_start;
  logic [6:0]  m_slave_addr;
  logic        m_rw;
  logic [7:0]  m_reg_addr;
  logic [2:0]  m_trans;
  logic [63:0] m_wdata;
  logic        m_busy;
  logic        m_nack;
  logic [63:0] m_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        seq_busy;

  modport slave (
    input  cmd_valid, cmd_slave_addr, cmd_rw, cmd_reg_addr, cmd_trans, cmd_wdata,
    input  m_busy, m_nack, m_rdata, rsp_ready,
    output cmd_ready, m_start, m_slave_addr, m_rw, m_reg_addr, m_trans, m_wdata,
    output rsp_valid, rsp_data, rsp_err, seq_busy
  );

  modport master (
    output cmd_valid, cmd_slave_addr, cmd_rw, cmd_reg_addr, cmd_trans, cmd_wdata,
    output m_busy, m_nack, m_rdata, rsp_ready,
    input  cmd_ready, m_start, m_slave_addr, m_rw, m_reg_addr, m_trans, m_wdata,
    input  rsp_valid, rsp_data, rsp_err, seq_busy
  );
endinterface

// File: rtl/i2c_cmd_fifo.sv
// Command FIFO; head entry is visible combinationally on o_data.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_400k,
  input  logic     rst,
  input  logic     i_push,
  input  i2c_cmd_t i_data,
  input  logic     i_pop,
  output i2c_cmd_t o_data,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  i2c_cmd_t      r_mem [DEPTH];
  logic          w_push, w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk_400k or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_400k) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/i2c_cmd_seq.sv
// Launches queued commands on the master one at a time, with NACK retry and
// accept/done watchdogs, and reports each outcome on the response channel.
module i2c_cmd_seq
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_RETRY      = 2,
  parameter int ACCEPT_TIMEOUT = 16,
  parameter int DONE_TIMEOUT   = 4096
) (
  input logic           clk_400k,
  input logic           rst,
  i2c_cmd_seq_if.slave  bus
);
  localparam int ATW = $clog2(ACCEPT_TIMEOUT);
  localparam int DTW = $clog2(DONE_TIMEOUT);
  localparam int RW  = $clog2(MAX_RETRY + 1);
  localparam logic [ATW-1:0] ACC_LAST  = ATW'(ACCEPT_TIMEOUT - 1);
  localparam logic [DTW-1:0] DONE_LAST = DTW'(DONE_TIMEOUT - 1);

  seq_state_e     r_state, w_state_nxt;
  i2c_cmd_t       r_cmd, w_head, w_in;
  logic [ATW-1:0] r_acc_tmr, w_acc_nxt;
  logic [DTW-1:0] r_done_tmr, w_done_nxt;
  logic [RW-1:0]  r_retry, w_retry_nxt;
  logic           r_rsp_valid, w_rsp_valid_nxt;
  logic [63:0]    r_rsp_data, w_rsp_data_nxt;
  rsp_err_e       r_rsp_err, w_rsp_err_nxt;
  logic           w_full, w_empty, w_pop;

  assign w_in = '{slave_addr: bus.cmd_slave_addr, rw: bus.cmd_rw,
                  reg_addr: bus.cmd_reg_addr, trans: bus.cmd_trans,
                  wdata: bus.cmd_wdata};

  i2c_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_400k (clk_400k),
    .rst      (rst),
    .i_push   (bus.cmd_valid),
    .i_data   (w_in),
    .i_pop    (w_pop),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign bus.cmd_ready    = !w_full;
  assign bus.m_start      = (r_state == LAUNCH);
  assign bus.m_slave_addr = r_cmd.slave_addr;
  assign bus.m_rw         = r_cmd.rw;
  assign bus.m_reg_addr   = r_cmd.reg_addr;
  assign bus.m_trans      = r_cmd.trans;
  assign bus.m_wdata      = r_cmd.wdata;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.seq_busy     = !w_empty || (r_state != IDLE);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc_tmr;
    w_done_nxt      = r_done_tmr;
    w_retry_nxt     = r_retry;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_pop           = 1'b0;
    unique case (r_state)
      IDLE: if (!w_empty && !bus.m_busy && !r_rsp_valid) begin
        w_pop       = 1'b1;
        w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        w_acc_nxt   = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.m_busy) begin
          w_done_nxt  = '0;
          w_state_nxt = WAIT_DONE;
        end else if (r_acc_tmr == ACC_LAST) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = ACC_TO;
          w_state_nxt     = RESPOND;
        end else begin
          w_acc_nxt = r_acc_tmr + 1'b1;
        end
      end
      WAIT_DONE: begin
        // busy can only be low here on its falling cycle: we entered with it high
        if (!bus.m_busy) begin
          if (bus.m_nack && (r_retry < RW'(MAX_RETRY))) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = LAUNCH;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = (!bus.m_nack && r_cmd.rw) ? bus.m_rdata : '0;
            w_rsp_err_nxt   = bus.m_nack ? NACK : OK;
            w_state_nxt     = RESPOND;
          end
        end else if (r_done_tmr == DONE_LAST) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = DONE_TO;
          w_state_nxt     = RESPOND;
        end else begin
          w_done_nxt = r_done_tmr + 1'b1;
        end
      end
      RESPOND: if (bus.rsp_ready) begin
        w_rsp_valid_nxt = 1'b0;
        w_retry_nxt     = '0;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_400k or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_acc_tmr   <= '0;
      r_done_tmr  <= '0;
      r_retry     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= OK;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_tmr   <= w_acc_nxt;
      r_done_tmr  <= w_done_nxt;
      r_retry     <= w_retry_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (w_pop) r_cmd <= w_head;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq with a behavioural I2C master model.
module tb_i2c_cmd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_cmd_seq_if bus ();

  i2c_cmd_seq #(
    .FIFO_DEPTH(4), .MAX_RETRY(2), .ACCEPT_TIMEOUT(16), .DONE_TIMEOUT(4096)
  ) dut (
    .clk_400k (clk),
    .rst      (rst),
    .bus      (bus)
  );

  // master model: 0 = normal, 1 = ignores start, 2 = stalled busy
  int          mdl_mode   = 0;
  int          mdl_cycles = 20;
  logic        mdl_nack   = 1'b0;
  logic        mdl_echo   = 1'b0;
  logic [63:0] mdl_rdata  = '0;
  int          mcnt       = 0;
  int          n_starts   = 0;
  int          n_chk      = 0;
  int          n_pass     = 0;

  always @(negedge clk) begin
    if (rst) begin
      bus.m_busy = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0; mcnt = 0;
    end else if (mcnt != 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        bus.m_busy  = 1'b0;
        bus.m_nack  = mdl_nack;
        bus.m_rdata = mdl_echo ? {56'd0, bus.m_reg_addr} : mdl_rdata;
      end
    end else if (mdl_mode == 2) begin
      bus.m_busy = 1'b1;
    end else if (mdl_mode == 0 && bus.m_start) begin
      bus.m_busy = 1'b1;
      mcnt = mdl_cycles;
    end else begin
      bus.m_busy = 1'b0;
    end
  end

  always @(posedge clk) if (bus.m_start) n_starts = n_starts + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [6:0] sa, input logic rw, input logic [7:0] ra,
                      input logic [2:0] tr, input logic [63:0] wd);
    bus.cmd_slave_addr = sa; bus.cmd_rw = rw; bus.cmd_reg_addr = ra;
    bus.cmd_trans = tr; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!bus.rsp_valid && k < 300) begin tick(); k++; end
    chk(tag, 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic accept();
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int s0;
    bus.cmd_valid = 1'b0; bus.cmd_slave_addr = '0; bus.cmd_rw = 1'b0;
    bus.cmd_reg_addr = '0; bus.cmd_trans = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_m_start",   64'(bus.m_start),   64'd0);
    chk("rst_m_reg",     64'(bus.m_reg_addr), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data",  bus.rsp_data,       64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("rst_seq_busy",  64'(bus.seq_busy),  64'd0);
    rst = 1'b0;
    tick(); tick();

    // write: start exactly two cycles after accept, one pulse
    mdl_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    s0 = n_starts;
    push(7'h3C, 1'b0, 8'h10, 3'd1, 64'hAB12 << 48);
    chk("wr_start_n1", 64'(bus.m_start), 64'd0);
    tick();
    chk("wr_start_n2", 64'(bus.m_start), 64'd1);
    chk("wr_m_reg",    64'(bus.m_reg_addr), 64'h10);
    chk("wr_m_addr",   64'(bus.m_slave_addr), 64'h3C);
    chk("wr_m_trans",  64'(bus.m_trans), 64'd1);
    chk("wr_m_wdata",  bus.m_wdata, 64'hAB12_0000_0000_0000);
    tick();
    chk("wr_start_n3", 64'(bus.m_start), 64'd0);
    wait_rsp("wr_rsp_to");
    chk("wr_err",    64'(bus.rsp_err), 64'd0);
    chk("wr_data",   bus.rsp_data, 64'd0);
    chk("wr_starts", 64'(n_starts - s0), 64'd1);
    accept();
    chk("wr_rsp_clr", 64'(bus.rsp_valid), 64'd0);

    // read with payload
    mdl_cycles = 6; mdl_rdata = 64'h0123_4567_89AB_CDEF;
    push(7'h50, 1'b1, 8'h22, 3'd7, 64'd0);
    wait_rsp("rd_rsp_to");
    chk("rd_data", bus.rsp_data, 64'h0123_4567_89AB_CDEF);
    chk("rd_err",  64'(bus.rsp_err), 64'd0);
    accept();

    // NACK every attempt: initial + 2 retries
    mdl_nack = 1'b1; mdl_cycles = 3;
    s0 = n_starts;
    push(7'h11, 1'b1, 8'h33, 3'd0, 64'd0);
    wait_rsp("nk_rsp_to");
    chk("nk_starts", 64'(n_starts - s0), 64'd3);
    chk("nk_err",    64'(bus.rsp_err), 64'd1);
    chk("nk_data",   bus.rsp_data, 64'd0);
    accept();
    mdl_nack = 1'b0;
    tick();

    // accept timeout; queued command still launches afterwards
    mdl_mode = 1;
    s0 = n_starts;
    push(7'h01, 1'b0, 8'h41, 3'd0, 64'd0);
    push(7'h02, 1'b1, 8'h42, 3'd0, 64'd0);
    chk("at_start", 64'(bus.m_start), 64'd1);
    chk("at_reg",   64'(bus.m_reg_addr), 64'h41);
    for (int i = 0; i < 16; i++) tick();
    chk("at_early", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("at_valid", 64'(bus.rsp_valid), 64'd1);
    chk("at_err",   64'(bus.rsp_err), 64'd2);
    chk("at_data",  bus.rsp_data, 64'd0);
    mdl_mode = 0; mdl_echo = 1'b1; mdl_cycles = 4;
    accept();
    wait_rsp("at2_rsp_to");
    chk("at2_data",   bus.rsp_data, 64'h42);
    chk("at2_err",    64'(bus.rsp_err), 64'd0);
    chk("at2_starts", 64'(n_starts - s0), 64'd2);
    accept();

    // fill FIFO with master stalled
    mdl_mode = 2;
    tick(); tick();
    for (int i = 0; i < 4; i++) push(7'h05, 1'b1, 8'h51 + 8'(i), 3'd0, 64'd0);
    chk("ff_full",  64'(bus.cmd_ready), 64'd0);
    chk("ff_busy",  64'(bus.seq_busy), 64'd1);
    bus.cmd_reg_addr = 8'h55; bus.cmd_valid = 1'b1;
    tick(); tick();
    chk("ff_full2", 64'(bus.cmd_ready), 64'd0);
    bus.cmd_valid = 1'b0;
    s0 = n_starts;
    mdl_mode = 0;
    wait_rsp("ff0_rsp_to");
    chk("ff0_data", bus.rsp_data, 64'h51);
    for (int i = 0; i < 5; i++) tick();
    chk("ff_hold_valid", 64'(bus.rsp_valid), 64'd1);
    chk("ff_no_launch",  64'(n_starts - s0), 64'd1);
    for (int i = 1; i < 4; i++) begin
      accept();
      wait_rsp("ffn_rsp_to");
      chk("ffn_data", bus.rsp_data, 64'h51 + 64'(i));
    end
    accept();
    tick();
    chk("ff_starts", 64'(n_starts - s0), 64'd4);
    chk("ff_idle",   64'(bus.seq_busy), 64'd0);

    // reset during WAIT_DONE with one command still queued
    mdl_cycles = 40;
    push(7'h06, 1'b1, 8'h61, 3'd0, 64'd0);
    push(7'h06, 1'b1, 8'h62, 3'd0, 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("mr_pre_busy", 64'(bus.seq_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mr_m_start",   64'(bus.m_start), 64'd0);
    chk("mr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mr_seq_busy",  64'(bus.seq_busy), 64'd0);
    tick(); tick();
    rst = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_post_idle", 64'(bus.seq_busy), 64'd0);
    chk("mr_no_start",  64'(n_starts - s0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
